// File: rtl/instruction_encoder.sv
// RV32I field-bundle to instruction-word encoder: range-checks the immediate, packs the word and
// writes it to instruction memory at an auto-incrementing word address (3 cycles/word, 2 per reject).
module instruction_encoder #(
  parameter int          ADDR_WIDTH = 14,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;

  localparam logic [1:0] EC_NONE   = 2'b00;
  localparam logic [1:0] EC_OPCODE = 2'b01;
  localparam logic [1:0] EC_RANGE  = 2'b10;
  localparam logic [1:0] EC_ALIGN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic [6:0]  r_opcode;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_func3;
  logic [6:0]  r_func7;
  logic [31:0] r_imm;

  // An immediate fits an N-bit signed field when all bits above the field's sign bit match it.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  assign w_fit12 = (&r_imm[31:11]) | ~(|r_imm[31:11]);
  assign w_fit13 = (&r_imm[31:12]) | ~(|r_imm[31:12]);
  assign w_fit21 = (&r_imm[31:20]) | ~(|r_imm[31:20]);

  logic [31:0] w_word;
  logic [1:0]  w_err_code;

  always_comb begin
    w_word     = '0;
    w_err_code = EC_NONE;
    case (r_opcode)
      OP_R: begin
        w_word = {r_func7, r_rs2, r_rs1, r_func3, r_rd, r_opcode};
      end
      OP_IALU, OP_LOAD: begin
        w_word = {r_imm[11:0], r_rs1, r_func3, r_rd, r_opcode};
        if (!w_fit12) w_err_code = EC_RANGE;
      end
      OP_S: begin
        w_word = {r_imm[11:5], r_rs2, r_rs1, r_func3, r_imm[4:0], r_opcode};
        if (!w_fit12) w_err_code = EC_RANGE;
      end
      OP_B: begin
        w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_func3, r_imm[4:1], r_imm[11], r_opcode};
        if (r_imm[0])      w_err_code = EC_ALIGN;
        else if (!w_fit13) w_err_code = EC_RANGE;
      end
      OP_J: begin
        w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
        if (r_imm[0])      w_err_code = EC_ALIGN;
        else if (!w_fit21) w_err_code = EC_RANGE;
      end
      default: w_err_code = EC_OPCODE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_mem_we   <= 1'b0;
      r_addr     <= LP_BASE;
      r_wdata    <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_func3    <= '0;
      r_func7    <= '0;
      r_imm      <= '0;
    end else if (clear) begin
      // Abandons any in-flight write, even one the memory is accepting this cycle.
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_mem_we   <= 1'b0;
      r_addr     <= LP_BASE;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_opcode   <= opcode;
            r_rd       <= rd;
            r_rs1      <= rs1;
            r_rs2      <= rs2;
            r_func3    <= func3;
            r_func7    <= func7;
            r_imm      <= imm;
            r_in_ready <= 1'b0;
            r_state    <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (w_err_code != EC_NONE) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wdata  <= w_word;
            r_mem_we <= 1'b1;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_mem_we   <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            if (r_count != '1) r_count <= r_count + (ADDR_WIDTH + 1)'(1);
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_mem_we   <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_count;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with a 2-bit address so wrap and count saturation are reachable.
module tb_instruction_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    func3 = '0;
  logic [6:0]    func7 = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b1;
  logic [AW:0]   word_count;
  logic          err;
  logic [1:0]    err_code;

  int n_vec = 0;
  int n_bad = 0;

  instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .func3      (func3),
    .func7      (func7),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .word_count (word_count),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("issue_ready_timeout", in_ready, 1);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic await_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
    int n = 0;
    while (!mem_we && n < 10) begin
      tick();
      n++;
    end
    check_eq({tag, "_we"}, mem_we, 1);
    check_eq({tag, "_addr"}, mem_addr, a);
    check_eq({tag, "_data"}, mem_wdata, d);
  endtask

  task automatic write_word(input string tag, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im,
                            input logic [AW-1:0] a, input logic [31:0] w);
    issue(op, d, s1, s2, f3, f7, im);
    await_write(tag, a, w);
    tick();
    check_eq({tag, "_done"}, mem_we, 0);
  endtask

  task automatic reject(input string tag, input logic [6:0] op, input logic [31:0] im,
                        input logic [1:0] code, input logic [AW-1:0] a);
    issue(op, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, im);
    check_eq({tag, "_we_enc"}, mem_we, 0);
    tick();
    check_eq({tag, "_err"}, err, 1);
    check_eq({tag, "_code"}, err_code, code);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_we"}, mem_we, 0);
    check_eq({tag, "_addr"}, mem_addr, a);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wrap_rd;
    repeat (3) tick();
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_count", word_count, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_code", err_code, 0);
    rst = 1'b0;
    tick();

    // add x3,x1,x2 with exact cycle timing
    issue(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    check_eq("add_ready_T0", in_ready, 0);
    check_eq("add_we_T0", mem_we, 0);
    tick();
    check_eq("add_we_T1", mem_we, 1);
    check_eq("add_addr", mem_addr, 0);
    check_eq("add_data", mem_wdata, 32'h002081B3);
    tick();
    check_eq("add_we_T2", mem_we, 0);
    check_eq("add_ready_T2", in_ready, 1);
    check_eq("add_count", word_count, 1);
    check_eq("add_addr_next", mem_addr, 1);

    do_clear();
    write_word("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 2'd0, 32'hFFF00093);
    write_word("sw", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 2'd1, 32'h0020A423);
    check_eq("sw_count", word_count, 2);

    // beq with a 4-cycle stall, then jal
    do_clear();
    mem_ready = 1'b0;
    issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    await_write("beq", 2'd0, 32'hFE208EE3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stall_we", mem_we, 1);
      check_eq("stall_addr", mem_addr, 0);
      check_eq("stall_data", mem_wdata, 32'hFE208EE3);
    end
    mem_ready = 1'b1;
    tick();
    check_eq("beq_done", mem_we, 0);
    write_word("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 2'd1, 32'h008000EF);

    // immediate boundaries accepted
    write_word("addi_min", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 2'd2, 32'h80000093);
    write_word("addi_max", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 2'd3, 32'h7FF00093);
    write_word("beq_max", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094, 2'd0, 32'h7E208FE3);
    write_word("beq_min", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4096, 2'd1, 32'h80208063);

    // rejections: address stays at 2 throughout
    reject("addi_2048", 7'b0010011, 32'd2048, 2'b10, 2'd2);
    reject("beq_odd", 7'b1100011, 32'd5, 2'b11, 2'd2);
    reject("lui_op", 7'b0110111, 32'd0, 2'b01, 2'd2);
    reject("jal_range", 7'b1101111, 32'd1048576, 2'b10, 2'd2);
    reject("jal_odd_range", 7'b1101111, 32'd1048577, 2'b11, 2'd2);
    reject("bad_op_odd", 7'b1111111, 32'd1048577, 2'b01, 2'd2);
    write_word("after_err", 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 2'd2, 32'h002081B3);
    check_eq("err_sticky", err, 1);
    check_eq("code_hold", err_code, 2'b01);
    do_clear();
    check_eq("clr_err", err, 0);
    check_eq("clr_code", err_code, 0);
    check_eq("clr_addr", mem_addr, 0);
    check_eq("clr_count", word_count, 0);

    // address wrap and count saturation
    for (int i = 0; i < 8; i++) begin
      wrap_rd = 5'(i + 4);
      write_word("wrap", 7'b0110011, wrap_rd, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 2'(i),
                 {7'd0, 5'd2, 5'd1, 3'd0, wrap_rd, 7'b0110011});
      if (i == 4) check_eq("count5", word_count, 5);
    end
    check_eq("count_sat", word_count, 7);
    check_eq("wrap_addr", mem_addr, 0);

    // clear wins over an accepted write
    issue(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    await_write("clrw", 2'd0, 32'h002081B3);
    mem_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clrw_we", mem_we, 0);
    check_eq("clrw_count", word_count, 0);
    check_eq("clrw_addr", mem_addr, 0);
    check_eq("clrw_ready", in_ready, 1);

    // async reset mid-write
    write_word("pre_rst", 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 2'd0, 32'h002081B3);
    reject("pre_rst_err", 7'b0000000, 32'd0, 2'b01, 2'd1);
    mem_ready = 1'b0;
    issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    await_write("rstw", 2'd1, 32'h00100093);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_we", mem_we, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_addr", mem_addr, 0);
    check_eq("arst_wdata", mem_wdata, 0);
    check_eq("arst_count", word_count, 0);
    check_eq("arst_err", err, 0);
    check_eq("arst_code", err_code, 0);
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
